// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and latched-request layout for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_STORE,
    ST_RSP
  } state_t;

  // Fields of an accepted request still needed after the word address is issued.
  typedef struct packed {
    logic [1:0]      size;
    logic            sgn;
    logic [1:0]      lane;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Reserved size always faults; alignment faults only when checking is enabled.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] lane,
                                          input logic       check);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = check & lane[0];
      SZ_WORD: mis = check & (lane != 2'b00);
      SZ_RSVD: mis = 1'b1;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends load data and merges sub-word store data into the old word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sgn,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [4:0]      shamt_c;
  logic [XLEN-1:0] mask_c;
  logic [XLEN-1:0] ins_c;

  always_comb begin
    byte_c      = 8'(rdata >> {lane, 3'b000});
    half_c      = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data_c = rdata;
    shamt_c     = 5'd0;
    mask_c      = '1;
    ins_c       = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c = {{24{sgn & byte_c[7]}}, byte_c};
        shamt_c     = {lane, 3'b000};
        mask_c      = 32'h0000_00FF << shamt_c;
        ins_c       = {24'd0, wdata[7:0]} << shamt_c;
      end
      SZ_HALF: begin
        load_data_c = {{16{sgn & half_c[15]}}, half_c};
        shamt_c     = {lane[1], 4'b0000};
        mask_c      = 32'h0000_FFFF << shamt_c;
        ins_c       = {16'd0, wdata[15:0]} << shamt_c;
      end
      default: ;
    endcase
    // Word size leaves mask all-ones, so the store data passes through whole.
    store_word_c = (rdata & ~mask_c) | (ins_c & mask_c);
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: one request at a time, read-modify-write for sub-word stores.
module lsu
  import lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wren,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state;
  lsu_req_t        lat;
  logic            misalign_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  assign misalign_c = lsu_misaligned(req_size, req_addr[1:0], 1'(CHECK_ALIGN));

  lsu_align u_align (
    .size         (lat.size),
    .sgn          (lat.sgn),
    .lane         (lat.lane),
    .rdata        (mem_rdata),
    .wdata        (lat.wdata),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Control FSM; every output is a register so memory/response ports are glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
    end else begin
      mem_wren  <= 1'b0;
      mem_wdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat <= '{size: req_size, sgn: req_signed, lane: req_addr[1:0], wdata: req_wdata};
            req_ready <= 1'b0;
            if (misalign_c) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_RSP;
            end else begin
              mem_addr <= {req_addr[XLEN-1:2], 2'b00};
              if (!req_wr) begin
                state <= ST_LOAD;
              end else if (req_size == SZ_WORD) begin
                mem_wren  <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= ST_STORE;
              end else begin
                state <= ST_READ;
              end
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata <= load_data_c;
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
        end
        // Old word is on mem_rdata now; the merged word becomes the write data.
        ST_READ: begin
          mem_wren  <= 1'b1;
          mem_wdata <= store_word_c;
          state     <= ST_STORE;
        end
        ST_STORE: begin
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            lat       <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: CHECK_ALIGN, 1, 1 = misaligned half/word requests complete with rsp_err and no memory access; 0 = addr low bits ignored for alignment.
REQ-002 clock  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready on a rising edge.
REQ-006 req_wr  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
REQ-008 req_signed  in  1  load sign-extension enable (lb/lh vs lbu/lhu); ignored for stores and words.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready on a rising edge.
REQ-013 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  out  1  request was misaligned or reserved size.
REQ-015 mem_addr  out  32  word address to data memory, {addr[31:2],2'b00}; 0 in IDLE.
REQ-016 mem_wdata  out  32  full word to write.
REQ-017 mem_wren  out  1  write strobe; memory writes on the same rising edge.
REQ-018 mem_rdata  in  32  combinational read of word at mem_addr, valid in the same cycle.

Function
REQ-019 FSM states: IDLE, LOAD, READ, STORE, RSP; req_ready = 1 only in IDLE.
REQ-020 IDLE: on handshake, latch all req_* fields; next state: misaligned -> RSP with err; load -> LOAD; word store -> STORE; byte/half store -> READ.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, size 11; no mem_wren asserted for such requests.
REQ-022 LOAD: capture mem_rdata, extract lane, extend, go to RSP.
REQ-023 READ: capture mem_rdata as old word, go to STORE.
REQ-024 STORE: mem_wren=1 for exactly one cycle, mem_wdata = word store data or old word with the addressed byte/half lane replaced, go to RSP.
REQ-025 Lanes little-endian: byte n = bits [8n+7:8n], n = addr[1:0]; half at addr[1]=0 bits [15:0], addr[1]=1 bits [31:16].
REQ-026 RSP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake go to IDLE; new request not accepted in the same cycle.
REQ-027 Latency from accept edge to rsp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-028 mem_wdata = 0 and mem_wren = 0 outside STORE.

Reset
REQ-029 reset low forces IDLE immediately: rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wren=0, mem_addr=0, mem_wdata=0, latched request cleared.
REQ-030 Reset in LOAD/READ aborts with no memory write; reset in STORE deasserts mem_wren asynchronously, so no write occurs at the next edge.
REQ-031 After reset release, first request is accepted on the first rising edge with req_valid=1.

Structure
REQ-032 Shared package lsu_pkg holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-033 One combinational sub-module lsu_align: load extract/extend and store lane merge; FSM and registers stay in lsu.

Verification
REQ-034 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> one mem_wren pulse; load rsp_rdata=0xDEADBEEF, 2-cycle latency.
REQ-035 Memory word 0x11223344 at 0x20; sb addr 0x22 data 0xAA -> READ then STORE writes 0x11AA3344, 3-cycle latency.
REQ-036 Same word 0x80FF7F01: lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01.
REQ-037 lw addr 0x06, sh addr 0x01 -> rsp_err=1 after 1 cycle, rsp_rdata=0, mem_wren never asserted.
REQ-038 Hold rsp_ready=0 five cycles -> rsp_valid and data stable, req_ready=0; then reset low during a STORE cycle -> no write, all outputs at reset values.
